// File: rtl/gf_pkg.sv
// gf_pkg
// Shared types and constants for the GF(2^N) exponentiation controller.
//   powState_e   : controller states IDLE / RUN / DONE
//   GF_ONE       : multiplicative identity, cast to N bits at the use site
//   invExponent  : exponent 2^N-2 whose power of x is x^-1 for x != 0
package gf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } powState_e;

   localparam int GF_ONE = 1;

   // By Fermat's little theorem in GF(2^N), x^(2^N-1) = 1, so x^(2^N-2) = x^-1.
   function automatic int invExponent(input int n);
      return (1 << n) - 2;
   endfunction

endpackage

// File: rtl/GF_square.sv
// GF_square
// Combinational squaring in GF(2^N), reduced modulo a full (N+1)-bit
// polynomial.
//   in   [N-1:0] : field element
//   prim [N:0]   : reduction polynomial, bit N expected set
//   out  [N-1:0] : in^2 mod prim
module GF_square #(
   parameter int N = 8
) (
   input  logic [N-1:0] in,
   input  logic [N:0]   prim,
   output logic [N-1:0] out
);

   logic [2*N-2:0] spread;

   // Squaring in characteristic 2 only spreads the bits apart (cross terms
   // cancel). The top bits are then folded back from the MSB downward.
   always_comb begin
      spread = '0;
      for (int i = 0; i < N; i++) begin
         spread[2*i] = in[i];
      end
      for (int i = 2*N-2; i >= N; i--) begin
         if (spread[i]) begin
            spread = spread ^ ((2*N-1)'(prim) << (i - N));
         end
      end
      out = spread[N-1:0];
   end

endmodule

// File: rtl/gf_mult.sv
// gf_mult
// Combinational N-bit multiplier in GF(2^N) using shift-and-add.
//   in1  [N-1:0] : multiplicand
//   in2  [N-1:0] : multiplier
//   prim [N-1:0] : low N bits of the reduction polynomial (bit N implied)
//   out  [N-1:0] : in1 * in2 mod prim
module gf_mult #(
   parameter int N = 8
) (
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic [N-1:0] prim,
   output logic [N-1:0] out
);

   logic [N-1:0] partial;
   logic [N-1:0] shifted;

   // shifted holds in1 * x^i, kept reduced. When a 1 falls off the top on
   // the shift, the implied x^N is replaced by the low polynomial bits.
   always_comb begin
      partial = '0;
      shifted = in1;
      for (int i = 0; i < N; i++) begin
         if (in2[i]) begin
            partial = partial ^ shifted;
         end
         shifted = shifted[N-1] ? ((shifted << 1) ^ prim) : (shifted << 1);
      end
      out = partial;
   end

endmodule

// File: rtl/gf_pow_ctrl.sv
// gf_pow_ctrl
// Computes base^exp in GF(2^N) by MSB-first square-and-multiply. It handles
// one exponent bit per clock, so latency is fixed at EW RUN cycles plus one
// DONE cycle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, sampled only while IDLE
//   base [N-1:0]   : element to exponentiate
//   exp  [EW-1:0]  : unsigned exponent
//   prim [N:0]     : reduction polynomial
//   inv            : inverse request (used only with GF_POW_INV_EN)
//   busy           : high during the EW RUN cycles
//   done           : one-cycle pulse; out is valid
//   out  [N-1:0]   : result, held until the next done
// Build option: define GF_POW_INV_EN so that inv=1 replaces exp with 2^N-2.
module gf_pow_ctrl
   import gf_pkg::*;
#(
   parameter int N  = 8,
   parameter int EW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [N-1:0]  base,
   input  logic [EW-1:0] exp,
   input  logic [N:0]    prim,
   input  logic          inv,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  out
);

   localparam int CW = (EW > 1) ? $clog2(EW) : 1;

   powState_e      state_q, state_d;
   logic [N-1:0]   acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   base_q, base_d;
   logic [EW-1:0]  exp_q, exp_d;
   logic [N:0]     prim_q, prim_d;
   logic [N-1:0]   out_q, out_d;

   logic [EW-1:0]  expSel;
   logic [N-1:0]   sq;
   logic [N-1:0]   prod;

`ifdef GF_POW_INV_EN
   // The inverse exponent must fit in the exponent register.
   generate
      if (EW < N) begin : gInvWidthCheck
         $error("gf_pow_ctrl: GF_POW_INV_EN needs EW >= N");
      end
   endgenerate

   assign expSel = inv ? EW'(invExponent(N)) : exp;
`else
   logic unusedInv;
   assign unusedInv = inv;
   assign expSel    = exp;
`endif

   GF_square #(.N(N)) uSquare (
      .in   (acc_q),
      .prim (prim_q),
      .out  (sq)
   );

   gf_mult #(.N(N)) uMult (
      .in1  (sq),
      .in2  (base_q),
      .prim (prim_q[N-1:0]),
      .out  (prod)
   );

   // State and datapath registers. Reset returns everything to zero and
   // drops any run in progress without issuing done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
         exp_q   <= '0;
         prim_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         exp_q   <= exp_d;
         prim_q  <= prim_d;
         out_q   <= out_d;
      end
   end

   // Next-state logic. start is ignored outside IDLE, so nothing is queued.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath. Operands are captured at acceptance, so input changes during
   // a run have no effect. The final step writes out directly, which makes
   // out valid in the same cycle that done is high.
   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      base_d = base_q;
      exp_d  = exp_q;
      prim_d = prim_q;
      out_d  = out_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               base_d = base;
               exp_d  = expSel;
               prim_d = prim;
               acc_d  = N'(GF_ONE);
               cnt_d  = CW'(EW - 1);
            end
         end
         RUN: begin
            acc_d = exp_q[cnt_q] ? prod : sq;
            if (cnt_q == '0) begin
               out_d = acc_d;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Outputs are decoded from the registered state.
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
      out  = out_q;
   end

endmodule
